piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register; next generation of the team's fixed 4-bit PISO.
- Adds the following over the 4-bit PISO:
  - configurable word width and bit order;
  - valid/ready load handshake;
  - shift-enable stall;
  - back-to-back frames;
  - end-of-frame pulse.
- Sits between a parallel datapath producer and a serial line driver or bit-serial consumer.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- LSB_FIRST, 0, bit order: 0 = MSB transmitted first, 1 = LSB transmitted first.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- par_in  input  WIDTH  parallel word to serialise.
- load_valid  input  1  producer offers par_in.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  consumer takes the current serial bit this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid frame bit.
- busy  output  1  frame in progress (equals ser_valid).
- done  output  1  one-cycle pulse after the final frame bit is consumed.

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous, active-low.
  - While rst_n=0: state=IDLE, shift register=0, bit counter=0, done=0.
  - Outputs during reset: ser_out=0, ser_valid=0, busy=0, load_ready=0.
  - load_ready rises in the first cycle after rst_n deasserts.
- States: IDLE and SHIFT (plus PARITY when the optional feature is compiled in).
- IDLE:
  - load_ready=1, ser_valid=0, ser_out=0.
  - Accept when load_valid && load_ready at a rising edge: shreg<=par_in, cnt<=0, state<=SHIFT.
- Latency: word accepted at edge N; first bit is on ser_out with ser_valid=1 in the cycle after edge N.
- SHIFT:
  - ser_out is shreg[WIDTH-1] (MSB first) or shreg[0] (LSB first), driven directly from the register, glitch-free.
  - At an edge with shift_en=1: shreg shifts toward the output end, zero fill; cnt<=cnt+1.
  - At an edge with shift_en=0: shreg, cnt and ser_out hold. Unlimited stall allowed.
- Last bit: the last bit is cnt==WIDTH-1. When it is consumed (shift_en=1):
  - state<=IDLE, or PARITY if enabled;
  - done<=1 for exactly one cycle.
- Back-to-back:
  - load_ready=1 in SHIFT only when cnt==WIDTH-1 && shift_en==1 (without parity).
  - An accept in that cycle reloads shreg, clears cnt and stays in SHIFT.
  - ser_valid stays high with no gap. done still pulses for the finished frame.
- load_valid while load_ready=0 is ignored; par_in is not sampled. The producer must hold it.
- cnt width is clog2(WIDTH+1). cnt never exceeds WIDTH-1 in SHIFT.
- Reset asserted mid-frame: the frame is abandoned immediately, with no done pulse, and all outputs go to reset values asynchronously.
- Frame length is WIDTH bits; WIDTH+1 with parity.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - Even parity bit (XOR of all par_in bits) is captured at accept.
  - After the last data bit is consumed, state goes to PARITY. ser_out = parity bit, ser_valid=1, and shift_en stall rules apply.
  - Consuming the parity bit gives done pulse, then IDLE; back-to-back load_ready is offered in this cycle instead.
  - Frame = WIDTH+1 bits.
- Undefined: no PARITY state or parity register; frame = WIDTH bits.

Test Plan:
- Bit order, MSB first: WIDTH=8, LSB_FIRST=0, load 0xC1, shift_en=1 constant -> ser_out 1,1,0,0,0,0,0,1 on 8 consecutive cycles starting 1 cycle after accept; done high in the 9th cycle only; then ser_valid=0.
- Bit order, LSB first: LSB_FIRST=1, load 0xC1 -> ser_out 1,0,0,0,0,0,1,1.
- Stall: load 0xC1 MSB-first, drop shift_en for 3 cycles after bit 2 -> ser_out holds 1 for those 3 cycles; sequence otherwise unchanged; done delayed by 3 cycles.
- Back-to-back: hold load_valid with 0xC1 then 0x3C -> 16 contiguous valid bits 1,1,0,0,0,0,0,1,0,0,1,1,1,1,0,0; load_ready pulses on the 8th bit; done pulses twice.
- Reset mid-frame: assert rst_n=0 after 4 bits of 0xFF -> ser_out=0, ser_valid=0 immediately, no done; after release, load 0x81 serialises correctly.
- Parity (PISO_PARITY_EN): load 0x07 -> 0,0,0,0,0,1,1,1 then parity 1; done after 9th bit. Load 0x03 -> parity 0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
//
// Purpose:
//   Bundles the load handshake and serial output of piso_serializer, so the
//   producer/consumer side and the serializer connect through one port.
//
// Parameters:
//   WIDTH        parallel word width in bits
//
// Signals:
//   par_in       parallel word offered by the producer
//   load_valid   producer offers par_in
//   load_ready   serializer can accept a word this cycle
//   shift_en     consumer takes the current serial bit this cycle
//   ser_out      current serial bit
//   ser_valid    ser_out holds a valid frame bit
//   busy         frame in progress (same as ser_valid)
//   done         one-cycle pulse after the final frame bit is consumed
//
// Modports:
//   master       producer / bit consumer side
//   slave        the serializer itself
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
   parameter int WIDTH = 8
) ();

   logic [WIDTH-1:0] par_in;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             done;

   modport master (
      output par_in,
      output load_valid,
      output shift_en,
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  par_in,
      input  load_valid,
      input  shift_en,
      output load_ready,
      output ser_out,
      output ser_valid,
      output busy,
      output done
   );

endinterface : piso_serializer_if

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Purpose:
//   Parameterised parallel-in/serial-out shift register with a valid/ready
//   load handshake, a shift-enable stall, gap-free back-to-back frames and a
//   one-cycle end-of-frame pulse.
//
// Parameters:
//   WIDTH        data word width in bits (>= 2)
//   LSB_FIRST    0: MSB transmitted first, 1: LSB transmitted first
//
// Optional feature:
//   PISO_PARITY_EN  when defined, an even parity bit (XOR of the word) is sent
//                   after the data bits; the frame becomes WIDTH+1 bits.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          piso_serializer_if.slave: par_in, load_valid, shift_en in;
//                load_ready, ser_out, ser_valid, busy, done out
// -----------------------------------------------------------------------------
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   piso_serializer_if.slave    bus
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2
   } state_e;
`else
   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             done_q,  done_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic             last_bit;
   logic             frame_end;
   logic             load_ready;
   logic             accept;
   logic [WIDTH-1:0] shreg_shifted;

   // Final data bit is on the line.
   assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

   // The final bit of the whole frame is consumed at the coming edge.
`ifdef PISO_PARITY_EN
   assign frame_end = (state_q == S_PARITY) && bus.shift_en;
`else
   assign frame_end = last_bit && bus.shift_en;
`endif

   // Gated by rst_n so the block never advertises readiness while held in
   // reset, and ready rises as soon as reset is released.
   assign load_ready = rst_n && ((state_q == S_IDLE) || frame_end);
   assign accept     = bus.load_valid && load_ready;

   // Shift toward the output end with zero fill.
   assign shreg_shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a hold default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      done_d   = frame_end;
`ifdef PISO_PARITY_EN
      parity_d = parity_q;
`endif

      unique case (state_q)
         S_IDLE: ;
         S_SHIFT: begin
            if (bus.shift_en) begin
               shreg_d = shreg_shifted;
               cnt_d   = cnt_q + 1'b1;
               if (last_bit) begin
                  cnt_d = '0;
`ifdef PISO_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_IDLE;
`endif
               end
            end
         end
`ifdef PISO_PARITY_EN
         S_PARITY: begin
            if (bus.shift_en) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // Accept is only possible in IDLE or as the frame finishes; either way
      // a fresh frame starts, which overrides the frame-end transition above.
      if (accept) begin
         shreg_d  = bus.par_in;
         cnt_d    = '0;
         state_d  = S_SHIFT;
`ifdef PISO_PARITY_EN
         parity_d = ^bus.par_in;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: ser_out is taken straight from a register (or a register mux
   // selected by the state register), so it cannot glitch on input changes.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.load_ready = load_ready;
      bus.ser_valid  = (state_q != S_IDLE);
      bus.busy       = (state_q != S_IDLE);
      bus.done       = done_q;
      // Zero fill guarantees shreg is all-zero in IDLE, so ser_out reads 0.
      bus.ser_out    = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
      if (state_q == S_PARITY) bus.ser_out = parity_q;
`endif
   end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Purpose:
//   Self-checking bench for piso_serializer (WIDTH=8). A reference model keeps
//   the expected serial bit stream as a queue: each accepted word appends its
//   frame bits, each consumed bit pops one. Readiness, valid, line value and
//   the done pulse are all derived from that queue. Directed frames are also
//   compared against hand-written bit patterns.
//
// Parameters:
//   LSB_FIRST    bit order passed to the DUT
//
// Optional feature:
//   PISO_PARITY_EN  must match the RTL build; adds the parity bit to frames.
// -----------------------------------------------------------------------------
module tb_piso_serializer #(
   parameter bit LSB_FIRST = 1'b0
);

   localparam int WIDTH = 8;

`ifdef PISO_PARITY_EN
   localparam int          FRAME   = WIDTH + 1;
   localparam logic [63:0] EXP_C1  = LSB_FIRST ? 64'h107   : 64'h183;
   localparam logic [63:0] EXP_B2B = LSB_FIRST ? 64'h20E78 : 64'h30678;
   localparam logic [63:0] EXP_81  = 64'h102;
`else
   localparam int          FRAME   = WIDTH;
   localparam logic [63:0] EXP_C1  = LSB_FIRST ? 64'h83    : 64'hC1;
   localparam logic [63:0] EXP_B2B = LSB_FIRST ? 64'h833C  : 64'hC13C;
   localparam logic [63:0] EXP_81  = 64'h81;
`endif

   logic clk;
   logic rst_n;

   piso_serializer_if #(.WIDTH(WIDTH)) bus ();

   piso_serializer #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model and stimulus state
   logic [WIDTH-1:0] prod_q[$];   // words waiting to be offered
   bit               presenting;  // prod_q[0] is on the bus, held until taken
   bit               exp_q[$];    // expected serial bits still to be consumed
   bit               done_exp;    // done expected in the current cycle
   bit               obs_q[$];    // bits actually seen on ser_out when consumed
   int               done_seen;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void push_frame(input logic [WIDTH-1:0] w);
      for (int i = 0; i < WIDTH; i++)
         exp_q.push_back(LSB_FIRST ? w[i] : w[WIDTH-1-i]);
`ifdef PISO_PARITY_EN
      exp_q.push_back(^w);
`endif
   endfunction

   function automatic logic [63:0] pack_obs();
      logic [63:0] v = '0;
      foreach (obs_q[i]) v = (v << 1) | 64'(obs_q[i]);
      return v;
   endfunction

   // One clock cycle: drive at posedge+1, check at negedge, advance the model
   // for the coming posedge.
   task automatic step(input bit se, input bit offer);
      bit m_ready;
      int n;
      if (!presenting && offer && prod_q.size() > 0) presenting = 1'b1;
      bus.load_valid = presenting;
      bus.par_in     = presenting ? prod_q[0] : WIDTH'($urandom);
      bus.shift_en   = se;
      @(negedge clk);
      n       = exp_q.size();
      m_ready = (n == 0) || (n == 1 && se);
      check("load_ready", bus.load_ready, m_ready);
      check("ser_valid",  bus.ser_valid,  n > 0);
      check("busy",       bus.busy,       n > 0);
      check("ser_out",    bus.ser_out,    (n > 0) ? exp_q[0] : 1'b0);
      check("done",       bus.done,       done_exp);
      if (bus.done === 1'b1) done_seen++;
      done_exp = 1'b0;
      if (n > 0 && se) begin
         obs_q.push_back(bus.ser_out);
         void'(exp_q.pop_front());
         if (exp_q.size() == 0) done_exp = 1'b1;
      end
      if (presenting && m_ready) begin
         push_frame(prod_q.pop_front());
         presenting = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Run with shift_en=1 until everything queued has been sent and done seen.
   task automatic drain();
      int budget = 200;
      while ((prod_q.size() > 0 || presenting || exp_q.size() > 0 || done_exp) && budget > 0) begin
         step(1'b1, 1'b1);
         budget--;
      end
      check("drain_timeout", (prod_q.size() > 0 || presenting || exp_q.size() > 0 || done_exp), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ser_out"},    bus.ser_out,    1'b0);
      check({tag, "_ser_valid"},  bus.ser_valid,  1'b0);
      check({tag, "_busy"},       bus.busy,       1'b0);
      check({tag, "_load_ready"}, bus.load_ready, 1'b0);
      check({tag, "_done"},       bus.done,       1'b0);
   endtask

   task automatic reset_model();
      exp_q.delete();
      prod_q.delete();
      presenting = 1'b0;
      done_exp   = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.load_valid = 1'b1;   // offered during reset: must be ignored
      bus.par_in     = 8'hA5;
      bus.shift_en   = 1'b1;
      reset_model();

      // Reset state
      #1;
      check_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      rst_n          = 1'b1;
      bus.load_valid = 1'b0;
      #1;
      check("rst_release_load_ready", bus.load_ready, 1'b1);
      check("rst_release_ser_valid",  bus.ser_valid,  1'b0);

      // Bit order: 0xC1 with shift_en held high
      obs_q.delete();
      prod_q.push_back(8'hC1);
      drain();
      step(1'b1, 1'b0);
      check("c1_len",  obs_q.size(), FRAME);
      check("c1_bits", pack_obs(), EXP_C1);

      // Stall: three idle cycles while the second bit is on the line
      obs_q.delete();
      prod_q.push_back(8'hC1);
      step(1'b1, 1'b1);                 // accept
      step(1'b1, 1'b0);                 // consume first bit
      repeat (3) step(1'b0, 1'b0);      // stall
      drain();
      check("stall_bits", pack_obs(), EXP_C1);

      // Back-to-back: 0xC1 then 0x3C with load_valid held
      obs_q.delete();
      done_seen = 0;
      prod_q.push_back(8'hC1);
      prod_q.push_back(8'h3C);
      drain();
      step(1'b1, 1'b0);
      check("b2b_len",  obs_q.size(), 2 * FRAME);
      check("b2b_bits", pack_obs(), EXP_B2B);
      check("b2b_done_count", done_seen, 2);

`ifdef PISO_PARITY_EN
      // Parity values
      obs_q.delete();
      prod_q.push_back(8'h07);
      drain();
      check("par07_bits", pack_obs(), LSB_FIRST ? 64'h1C1 : 64'h00F);
      obs_q.delete();
      prod_q.push_back(8'h03);
      drain();
      check("par03_bits", pack_obs(), LSB_FIRST ? 64'h180 : 64'h006);
`endif

      // Reset mid-frame after four bits of 0xFF
      prod_q.push_back(8'hFF);
      step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);
      check("midrst_pre_valid", bus.ser_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      reset_model();
      @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      rst_n = 1'b1;
      #1;
      check("midrst_release_ready", bus.load_ready, 1'b1);
      obs_q.delete();
      prod_q.push_back(8'h81);
      drain();
      check("post_rst_bits", pack_obs(), EXP_81);

      // Randomised traffic: random words, offers and stalls
      for (int i = 0; i < 3000; i++) begin
         if (prod_q.size() < 2) prod_q.push_back(WIDTH'($urandom));
         step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
      end
      drain();
      step(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_piso_serializer
